// File: rtl/ml_controller.sv
// Multi-cycle controller: sequences fetch/decode/execute and drives datapath enables.
// Ports: clk, reset (async high), cond/op/funct/sh/alu_flags in; datapath controls, state out. Option: ML_CTRL_LINK_EN.
module ml_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [2:0] sh,
  input  logic [3:0] alu_flags,
  output logic       adr_source,
  output logic       mem_Write,
  output logic       ir_Write,
  output logic       reg_Write,
  output logic       pc_Write,
  output logic       alu_srcA,
  output logic [2:0] alu_control,
  output logic [1:0] alu_srcB,
  output logic [1:0] imm_src,
  output logic [3:0] RegSrc,
  output logic [1:0] result_src,
  output logic [2:0] shft_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_LINK   = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_flags;
  logic       r_condex;
  logic       w_condex;
  logic [3:0] w_cmd;
  logic       w_cmp;
  logic       w_exec;
  logic [2:0] w_alu_cmd;
  logic       w_mem_we;
  logic       w_ir_we;
  logic       w_reg_we;
  logic       w_pc_we;

  assign w_cmd  = funct[4:1];
  assign w_cmp  = (w_cmd == 4'b1010);
  assign w_exec = (r_state == S_EXECR) ||
                  (r_state == S_EXECI);

  // flags are {N,Z,C,V}
  always_comb begin
    w_condex = 1'b0;
    case (cond)
      4'b1110: w_condex = 1'b1;
      4'b0000: w_condex = r_flags[2];
      4'b0001: w_condex = ~r_flags[2];
      4'b1010: w_condex = (r_flags[3] == r_flags[0]);
      4'b1011: w_condex = (r_flags[3] != r_flags[0]);
      default: w_condex = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_cmd = 3'b000;
    case (w_cmd)
      4'b0100: w_alu_cmd = 3'b000;
      4'b0010: w_alu_cmd = 3'b001;
      4'b0000: w_alu_cmd = 3'b010;
      4'b1100: w_alu_cmd = 3'b011;
      4'b1010: w_alu_cmd = 3'b001;
      4'b1101: w_alu_cmd = 3'b100;
      default: w_alu_cmd = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_flags  <= 4'b0000;
      r_condex <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_condex <= w_condex;
      // compares always set flags, other ops only when S is set
      if (w_exec && r_condex && (funct[0] || w_cmp))
        r_flags <= alu_flags;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    adr_source  = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_we     = 1'b0;
    w_reg_we    = 1'b0;
    w_pc_we     = 1'b0;
    alu_srcA    = 1'b0;
    alu_control = 3'b000;
    alu_srcB    = 2'b00;
    imm_src     = op;
    RegSrc      = 4'b0000;
    result_src  = 2'b00;
    shft_op     = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_ir_we    = 1'b1;
        alu_srcA   = 1'b1;
        alu_srcB   = 2'b10;
        result_src = 2'b10;
        w_pc_we    = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_srcB = 2'b01;
        w_next   = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_source = 1'b1;
        w_next     = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        w_reg_we   = r_condex;
      end
      S_MEMWR: begin
        adr_source = 1'b1;
        RegSrc     = 4'b0010;
        w_mem_we   = r_condex;
      end
      S_EXECR: begin
        alu_control = w_alu_cmd;
        shft_op     = sh;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_srcB    = 2'b01;
        alu_control = w_alu_cmd;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_we = r_condex && !w_cmp;
      end
      S_BRANCH: begin
        RegSrc     = 4'b0001;
        alu_srcA   = 1'b1;
        alu_srcB   = 2'b01;
        result_src = 2'b10;
        w_pc_we    = r_condex;
`ifdef ML_CTRL_LINK_EN
        w_next     = funct[4] ? S_LINK : S_FETCH;
`else
        w_next     = S_FETCH;
`endif
      end
`ifdef ML_CTRL_LINK_EN
      S_LINK: begin
        RegSrc     = 4'b1100;
        result_src = 2'b00;
        w_reg_we   = r_condex;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // FETCH is held during reset; its enables must not leak out
  assign mem_Write = w_mem_we & ~reset;
  assign ir_Write  = w_ir_we  & ~reset;
  assign reg_Write = w_reg_we & ~reset;
  assign pc_Write  = w_pc_we  & ~reset;
  assign state     = r_state;

endmodule

// File: tb/tb_ml_controller.sv
// Bench for ml_controller: instruction-level model, per-cycle compare.
// Directed literal checks plus random instructions.
module tb_ml_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [2:0] sh;
  logic [3:0] alu_flags;
  logic       adr_source;
  logic       mem_Write;
  logic       ir_Write;
  logic       reg_Write;
  logic       pc_Write;
  logic       alu_srcA;
  logic [2:0] alu_control;
  logic [1:0] alu_srcB;
  logic [1:0] imm_src;
  logic [3:0] RegSrc;
  logic [1:0] result_src;
  logic [2:0] shft_op;
  logic [3:0] state;

  ml_controller dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op),
    .funct(funct), .sh(sh), .alu_flags(alu_flags),
    .adr_source(adr_source), .mem_Write(mem_Write),
    .ir_Write(ir_Write), .reg_Write(reg_Write),
    .pc_Write(pc_Write), .alu_srcA(alu_srcA),
    .alu_control(alu_control), .alu_srcB(alu_srcB),
    .imm_src(imm_src), .RegSrc(RegSrc),
    .result_src(result_src), .shft_op(shft_op),
    .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk = 1'b0;
  int m_state = 0;
  bit m_condex = 1'b0;
  logic [3:0] m_flags = 4'b0000;
  int seq_q[$];
  int obs_q[$];
  logic last_mw;

  function automatic bit cx_f(logic [3:0] c, logic [3:0] fl);
    case (c)
      4'b1110: return 1'b1;
      4'b0000: return fl[2];
      4'b0001: return !fl[2];
      4'b1010: return fl[3] == fl[0];
      4'b1011: return fl[3] != fl[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_f(logic [3:0] c);
    case (c)
      4'b0010: return 3'd1;
      4'b0000: return 3'd2;
      4'b1100: return 3'd3;
      4'b1010: return 3'd1;
      4'b1101: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // bundle: adr,mw,iw,rw,pw,srcA,aluctl,srcB,imm,RegSrc,res,shft
  function automatic logic [21:0] exp_out(int st, bit cx,
      logic [1:0] o, logic [5:0] f, logic [2:0] s);
    logic adr, mw, iw, rw, pw, sa;
    logic [2:0] ac, so;
    logic [1:0] sb, res;
    logic [3:0] rs;
    adr = 0; mw = 0; iw = 0; rw = 0; pw = 0; sa = 0;
    ac = 0; so = 0; sb = 0; res = 0; rs = 0;
    case (st)
      0: begin iw = 1; sa = 1; sb = 2; res = 2; pw = 1; end
      2: sb = 1;
      3: adr = 1;
      4: begin res = 1; rw = cx; end
      5: begin adr = 1; rs = 4'b0010; mw = cx; end
      6: begin ac = alu_f(f[4:1]); so = s; end
      7: begin ac = alu_f(f[4:1]); sb = 1; end
      8: rw = cx && (f[4:1] != 4'b1010);
      9: begin rs = 1; sa = 1; sb = 1; res = 2; pw = cx; end
`ifdef ML_CTRL_LINK_EN
      10: begin rs = 4'b1100; rw = cx; end
`endif
      default: ;
    endcase
    return {adr, mw, iw, rw, pw, sa, ac, sb, o, rs, res, so};
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      logic [21:0] e, g;
      e = exp_out(m_state, m_condex, op, funct, sh);
      g = {adr_source, mem_Write, ir_Write, reg_Write, pc_Write,
           alu_srcA, alu_control, alu_srcB, imm_src, RegSrc,
           result_src, shft_op};
      checks++;
      obs_q.push_back(int'(state));
      if (state == 4'd5) last_mw = mem_Write;
      if (int'(state) != m_state || g !== e) begin
        errors++;
        $display("FAIL cycle t=%0t state got=%0d exp=%0d outs got=%h exp=%h",
                 $time, state, m_state, g, e);
      end
    end
  end

  task automatic chk_eq(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic chk_seq(string n, int e[$]);
    bit bad;
    bad = (obs_q.size() != e.size());
    if (!bad)
      foreach (e[i]) if (obs_q[i] != e[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s seq got=%p exp=%p", n, obs_q, e);
    end
  endtask

  task automatic build_seq(logic [1:0] o, logic [5:0] f);
    seq_q.delete();
    seq_q.push_back(0);
    seq_q.push_back(1);
    case (o)
      2'b01: begin
        seq_q.push_back(2);
        if (f[0]) begin seq_q.push_back(3); seq_q.push_back(4); end
        else seq_q.push_back(5);
      end
      2'b00: begin
        seq_q.push_back(f[5] ? 7 : 6);
        seq_q.push_back(8);
      end
      2'b10: begin
        seq_q.push_back(9);
`ifdef ML_CTRL_LINK_EN
        if (f[4]) seq_q.push_back(10);
`endif
      end
      default: ;
    endcase
  endtask

  // one cycle in model state st; model updates at the edge leaving it
  task automatic step(int st);
    m_state = st;
    @(posedge clk);
    if (st == 1) m_condex = cx_f(cond, m_flags);
    if ((st == 6 || st == 7) && m_condex &&
        (funct[0] || funct[4:1] == 4'b1010))
      m_flags = alu_flags;
    #1;
  endtask

  task automatic run_instr(logic [3:0] c, logic [1:0] o,
      logic [5:0] f, logic [2:0] s, logic [3:0] fl);
    cond = c; op = o; funct = f; sh = s; alu_flags = fl;
    obs_q.delete();
    build_seq(o, f);
    chk = 1'b1;
    foreach (seq_q[i]) step(seq_q[i]);
    m_state = 0;
  endtask

  initial begin
    logic [3:0] cs [6];
    reset = 1'b1;
    cond = 0; op = 0; funct = 0; sh = 0; alu_flags = 0;
    #2;
    chk_eq("rst_state_async", int'(state), 0);
    @(negedge clk);
    chk_eq("rst_state", int'(state), 0);
    chk_eq("rst_we", int'({ir_Write, pc_Write, reg_Write, mem_Write}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(4'b1110, 2'b00, 6'b001000, 3'b101, 4'b0000);
    chk_seq("add", '{0, 1, 6, 8});
    run_instr(4'b1110, 2'b01, 6'b000001, 3'b000, 4'b0000);
    chk_seq("load", '{0, 1, 2, 3, 4});
    run_instr(4'b1110, 2'b00, 6'b010100, 3'b000, 4'b0100);
    chk_seq("cmp", '{0, 1, 6, 8});
    chk_eq("cmp_flags_model", int'(m_flags), 4);
    run_instr(4'b0000, 2'b01, 6'b000000, 3'b000, 4'b0000);
    chk_seq("store_eq", '{0, 1, 2, 5});
    chk_eq("store_eq_mw", int'(last_mw), 1);
    run_instr(4'b0001, 2'b01, 6'b000000, 3'b000, 4'b0000);
    chk_eq("store_ne_mw", int'(last_mw), 0);
    run_instr(4'b1110, 2'b11, 6'b111111, 3'b111, 4'b1111);
    chk_seq("illegal", '{0, 1});
    run_instr(4'b1110, 2'b10, 6'b010000, 3'b000, 4'b0000);
`ifdef ML_CTRL_LINK_EN
    chk_seq("branch_link", '{0, 1, 9, 10});
`else
    chk_seq("branch_link", '{0, 1, 9});
`endif
    run_instr(4'b1110, 2'b00, 6'b111011, 3'b000, 4'b1001);
    chk_seq("movi", '{0, 1, 7, 8});

    // set Z again, then reset during MEMRD
    run_instr(4'b1110, 2'b00, 6'b010100, 3'b000, 4'b0100);
    cond = 4'b1110; op = 2'b01; funct = 6'b000001;
    step(0); step(1); step(2);
    m_state = 3;
    @(negedge clk);
    #2;
    reset = 1'b1;
    chk = 1'b0;
    #1;
    chk_eq("midrst_state", int'(state), 0);
    chk_eq("midrst_we",
           int'({ir_Write, pc_Write, reg_Write, mem_Write}), 0);
    @(posedge clk); #1;
    chk_eq("midrst_hold",
           int'({state, ir_Write, pc_Write, reg_Write, mem_Write}), 0);
    m_flags = 0; m_condex = 0; m_state = 0;
    reset = 1'b0;
    run_instr(4'b0000, 2'b01, 6'b000000, 3'b000, 4'b0000);
    chk_eq("post_rst_flags_clear", int'(last_mw), 0);

    cs[0] = 4'b1110; cs[1] = 4'b0000; cs[2] = 4'b0001;
    cs[3] = 4'b1010; cs[4] = 4'b1011;
    for (int k = 0; k < 300; k++) begin
      cs[5] = 4'($urandom);
      run_instr(cs[$urandom_range(0, 5)], 2'($urandom),
                6'($urandom), 3'($urandom), 4'($urandom));
    end
    @(negedge clk); #1;
    chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
